// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, branch redirect and decode handshake.
// Latency: n/a (wires only).
// Backpressure: InstrReady from decode stalls the fetch buffer.
//
// master : the fetch unit (drives CurrentPC and the decode-facing outputs)
// slave  : the environment (instruction memory, branch unit, decode)
interface fetch_unit_if;
  logic [31:0] CurrentPC;
  logic [31:0] Instruction;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] InstrOut;
  logic [31:0] InstrPC;
  logic        FetchFault;

  modport master (
    output CurrentPC, InstrValid, InstrOut, InstrPC, FetchFault,
    input  Instruction, BranchTaken, BranchTarget, InstrReady
  );

  modport slave (
    input  CurrentPC, InstrValid, InstrOut, InstrPC, FetchFault,
    output Instruction, BranchTaken, BranchTarget, InstrReady
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch unit: owns the PC, captures {PC, Instruction} into a 2-entry buffer for decode.
// Latency: an instruction appears at InstrOut one cycle after its PC is on CurrentPC.
// Backpressure: buffer full and no pop -> PC holds and memory is re-read next cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   fu (master)       CurrentPC/Instruction to imem, BranchTaken/BranchTarget redirect,
//                     InstrValid/InstrReady/InstrOut/InstrPC to decode, FetchFault flag
// Build option: FETCH_BOUNDS_CHECK_EN adds an instruction-memory range check that stops
// fetching at PC >= IMEM_WORDS*4 and raises a sticky FetchFault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master fu
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_pc_q  [2];
  logic [31:0] buf_ins_q [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;

  logic        fetch_en;
  logic        push;
  logic        pop;
  logic        instr_valid;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

  logic fault_q, fault_d;

  assign fetch_en = ({1'b0, pc_q} < IMEM_BYTES);

  // Sticky once an out-of-range PC is seen; only a redirect can move the PC away.
  always_comb begin
    fault_d = fault_q | ~fetch_en;
    if (fu.BranchTaken) begin
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fu.FetchFault = fault_q;
`else
  assign fetch_en      = 1'b1;
  assign fu.FetchFault = 1'b0;
`endif

  assign instr_valid = (count_q != 2'd0);
  assign pop         = instr_valid & fu.InstrReady;
  // A full buffer can still accept when the head leaves in the same cycle.
  assign push        = fetch_en & ((count_q != 2'd2) | pop);

  assign fu.CurrentPC  = pc_q;
  assign fu.InstrValid = instr_valid;
  assign fu.InstrOut   = buf_ins_q[rd_ptr_q];
  assign fu.InstrPC    = buf_pc_q[rd_ptr_q];

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (fu.BranchTaken) begin
      // Redirect wins over push and pop: discard everything, including the word
      // fetched this cycle. Keeping the head pointer leaves InstrOut stable.
      pc_d     = {fu.BranchTarget[31:2], 2'b00};
      count_d  = 2'd0;
      wr_ptr_d = rd_ptr_q;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC_ALIGNED;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_pc_q[i]  <= 32'd0;
        buf_ins_q[i] <= 32'd0;
      end
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push && !fu.BranchTaken) begin
        buf_pc_q[wr_ptr_q]  <= pc_q;
        buf_ins_q[wr_ptr_q] <= fu.Instruction;
      end
    end
  end

endmodule
